// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: widths, default
// exception vector, FSM state encodings and the register-match helper.
package pipeline_hazard_ctrl_pkg;

    localparam int DP_WIDTH  = 32;
    localparam int REG_WIDTH = 5;

    localparam logic [DP_WIDTH-1:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } hz_state_e;

    // Register $zero never carries a dependency.
    function automatic logic src_match(
        input logic                 en,
        input logic [REG_WIDTH-1:0] src,
        input logic [REG_WIDTH-1:0] dst
    );
        return en && (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: flags dependencies that forwarding cannot
// cover, so the front end must stall for a cycle.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_WIDTH-1:0] id_rs,
    input  logic [REG_WIDTH-1:0] id_rt,
    input  logic                 id_need_rs,
    input  logic                 id_need_rt,
    input  logic                 id_want_rs,
    input  logic                 id_want_rt,
    input  logic [REG_WIDTH-1:0] ex_rtrd,
    input  logic                 ex_regwrite,
    input  logic                 ex_memread,
    input  logic [REG_WIDTH-1:0] mem_rtrd,
    input  logic                 mem_memread,
    output logic                 load_use
);

    logic ex_need_hit;
    logic ex_want_hit;
    logic mem_need_hit;

    // ID-stage consumers cannot take any EX result; EX-stage consumers only miss loads.
    always_comb begin
        ex_need_hit  = src_match(id_need_rs, id_rs, ex_rtrd)
                     | src_match(id_need_rt, id_rt, ex_rtrd);
        ex_want_hit  = src_match(id_want_rs, id_rs, ex_rtrd)
                     | src_match(id_want_rt, id_rt, ex_rtrd);
        mem_need_hit = src_match(id_need_rs, id_rs, mem_rtrd)
                     | src_match(id_need_rt, id_rt, mem_rtrd);
        load_use     = (ex_regwrite & ex_need_hit)
                     | (ex_memread  & ex_want_hit)
                     | (mem_memread & mem_need_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: prioritises exceptions, data-memory waits,
// load-use hazards and fetch waits, and runs the exception restart sequence.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter logic [DP_WIDTH-1:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int                  DMEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IF_MemReady,
    input  logic [REG_WIDTH-1:0] ID_Rs,
    input  logic [REG_WIDTH-1:0] ID_Rt,
    input  logic                 ID_NeedRs,
    input  logic                 ID_NeedRt,
    input  logic                 ID_WantRs,
    input  logic                 ID_WantRt,
    input  logic [REG_WIDTH-1:0] EX_RtRd,
    input  logic                 EX_RegWrite,
    input  logic                 EX_MemRead,
    input  logic [REG_WIDTH-1:0] MEM_RtRd,
    input  logic                 MEM_RegWrite,
    input  logic                 MEM_MemRead,
    input  logic                 MEM_MemWrite,
    input  logic                 MEM_MemReady,
    input  logic                 MEM_Exception,
    input  logic [DP_WIDTH-1:0]  MEM_RestartPC,
    input  logic                 MEM_IsBDS,
    output logic                 IF_Stall,
    output logic                 ID_Stall,
    output logic                 EX_Stall,
    output logic                 MEM_Stall,
    output logic                 WB_Stall,
    output logic                 IF_Flush,
    output logic                 ID_Flush,
    output logic                 EX_Flush,
    output logic                 MEM_Flush,
    output logic                 PC_Redirect,
    output logic [DP_WIDTH-1:0]  PC_Target,
    output logic [DP_WIDTH-1:0]  EPC,
    output logic                 ExcBD,
    output logic                 ExcBusErr
);

    localparam int CNT_W = $clog2(DMEM_TIMEOUT);

    hz_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DP_WIDTH-1:0]  epc_q, epc_d;
    logic                 bd_q, bd_d;
    logic                 buserr_q, buserr_d;

    logic                 load_use;
    logic                 dmem_wait;
    logic                 timeout;
    logic                 exc;
    logic [3:0]           stall;
    logic                 flush_all;
    logic                 redirect;

    hazard_detect u_hazard_detect (
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .id_need_rs  (ID_NeedRs),
        .id_need_rt  (ID_NeedRt),
        .id_want_rs  (ID_WantRs),
        .id_want_rt  (ID_WantRt),
        .ex_rtrd     (EX_RtRd),
        .ex_regwrite (EX_RegWrite),
        .ex_memread  (EX_MemRead),
        .mem_rtrd    (MEM_RtRd),
        .mem_memread (MEM_MemRead),
        .load_use    (load_use)
    );

    always_comb begin
        dmem_wait = (MEM_MemRead | MEM_MemWrite) & ~MEM_MemReady;
        timeout   = (cnt_q == CNT_W'(DMEM_TIMEOUT - 1)) & dmem_wait;
        exc       = MEM_Exception | timeout;
    end

    // stall[3:0] = {IF, ID, EX, MEM}; the counter clears by default.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        epc_d     = epc_q;
        bd_d      = bd_q;
        buserr_d  = buserr_q;
        stall     = 4'b0000;
        flush_all = 1'b0;
        redirect  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (exc) begin
                    flush_all = 1'b1;
                    epc_d     = MEM_RestartPC;
                    bd_d      = MEM_IsBDS;
                    buserr_d  = timeout;
                    state_d   = ST_EXC;
                end else if (dmem_wait) begin
                    stall = 4'b1111;
                    cnt_d = cnt_q + 1'b1;
                end else if (load_use) begin
                    stall = 4'b1100;
                end else if (!IF_MemReady) begin
                    stall = 4'b1000;
                end
            end
            ST_EXC: begin
                flush_all = 1'b1;
                redirect  = 1'b1;
                state_d   = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            epc_q    <= '0;
            bd_q     <= 1'b0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            epc_q    <= epc_d;
            bd_q     <= bd_d;
            buserr_q <= buserr_d;
        end
    end

    // Control outputs are forced quiet while reset is held.
    assign IF_Stall    = rst & stall[3];
    assign ID_Stall    = rst & stall[2];
    assign EX_Stall    = rst & stall[1];
    assign MEM_Stall   = rst & stall[0];
    assign WB_Stall    = 1'b0;
    assign IF_Flush    = rst & flush_all;
    assign ID_Flush    = rst & flush_all;
    assign EX_Flush    = rst & flush_all;
    assign MEM_Flush   = rst & flush_all;
    assign PC_Redirect = rst & redirect;
    assign PC_Target   = PC_Redirect ? EXC_VECTOR : '0;
    assign EPC         = epc_q;
    assign ExcBD       = bd_q;
    assign ExcBusErr   = buserr_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a behavioural model fills a
// scoreboard queue as each cycle is driven; entries are checked mid-cycle.
module tb_pipeline_hazard_ctrl;

    localparam logic [31:0] VEC     = 32'h8000_0180;
    localparam int          TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        IF_MemReady;
    logic [4:0]  ID_Rs, ID_Rt;
    logic        ID_NeedRs, ID_NeedRt, ID_WantRs, ID_WantRt;
    logic [4:0]  EX_RtRd;
    logic        EX_RegWrite, EX_MemRead;
    logic [4:0]  MEM_RtRd;
    logic        MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemReady;
    logic        MEM_Exception;
    logic [31:0] MEM_RestartPC;
    logic        MEM_IsBDS;
    logic        IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall;
    logic        IF_Flush, ID_Flush, EX_Flush, MEM_Flush;
    logic        PC_Redirect;
    logic [31:0] PC_Target, EPC;
    logic        ExcBD, ExcBusErr;

    pipeline_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .IF_MemReady  (IF_MemReady),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_NeedRs    (ID_NeedRs),
        .ID_NeedRt    (ID_NeedRt),
        .ID_WantRs    (ID_WantRs),
        .ID_WantRt    (ID_WantRt),
        .EX_RtRd      (EX_RtRd),
        .EX_RegWrite  (EX_RegWrite),
        .EX_MemRead   (EX_MemRead),
        .MEM_RtRd     (MEM_RtRd),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_MemReady (MEM_MemReady),
        .MEM_Exception(MEM_Exception),
        .MEM_RestartPC(MEM_RestartPC),
        .MEM_IsBDS    (MEM_IsBDS),
        .IF_Stall     (IF_Stall),
        .ID_Stall     (ID_Stall),
        .EX_Stall     (EX_Stall),
        .MEM_Stall    (MEM_Stall),
        .WB_Stall     (WB_Stall),
        .IF_Flush     (IF_Flush),
        .ID_Flush     (ID_Flush),
        .EX_Flush     (EX_Flush),
        .MEM_Flush    (MEM_Flush),
        .PC_Redirect  (PC_Redirect),
        .PC_Target    (PC_Target),
        .EPC          (EPC),
        .ExcBD        (ExcBD),
        .ExcBusErr    (ExcBusErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  stall;
        logic [3:0]  flush;
        logic        redir;
        logic [31:0] target;
        logic [31:0] epc;
        logic        bd;
        logic        buserr;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];

    int vectorCount = 0;
    int failCount   = 0;

    // Reference model state
    bit          mInExc;
    int          mCnt;
    logic [31:0] mEpc;
    logic        mBd;
    logic        mBusErr;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectorCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    function automatic bit hit(input logic en, input logic [4:0] src, input logic [4:0] dst);
        return en && (src != 5'd0) && (src == dst);
    endfunction

    task automatic clearInputs();
        IF_MemReady   = 1'b1;
        ID_Rs         = '0;
        ID_Rt         = '0;
        ID_NeedRs     = 1'b0;
        ID_NeedRt     = 1'b0;
        ID_WantRs     = 1'b0;
        ID_WantRt     = 1'b0;
        EX_RtRd       = '0;
        EX_RegWrite   = 1'b0;
        EX_MemRead    = 1'b0;
        MEM_RtRd      = '0;
        MEM_RegWrite  = 1'b0;
        MEM_MemRead   = 1'b0;
        MEM_MemWrite  = 1'b0;
        MEM_MemReady  = 1'b1;
        MEM_Exception = 1'b0;
        MEM_RestartPC = '0;
        MEM_IsBDS     = 1'b0;
    endtask

    // Drive one cycle: the currently set inputs are modelled, the expectation
    // queued, the outputs checked at the falling edge, and the model clocked.
    task automatic applyStimulus(input string tag);
        exp_t e;
        exp_t got;
        string t;
        bit dw, to, lu, ex;
        if (!rst) begin
            mInExc = 0; mCnt = 0; mEpc = '0; mBd = 1'b0; mBusErr = 1'b0;
        end
        dw = (MEM_MemRead || MEM_MemWrite) && !MEM_MemReady;
        to = dw && (mCnt == TIMEOUT - 1);
        ex = MEM_Exception || to;
        lu = (EX_RegWrite && (hit(ID_NeedRs, ID_Rs, EX_RtRd) || hit(ID_NeedRt, ID_Rt, EX_RtRd)))
          || (EX_MemRead  && (hit(ID_WantRs, ID_Rs, EX_RtRd) || hit(ID_WantRt, ID_Rt, EX_RtRd)))
          || (MEM_MemRead && (hit(ID_NeedRs, ID_Rs, MEM_RtRd) || hit(ID_NeedRt, ID_Rt, MEM_RtRd)));
        e = '0;
        e.epc    = mEpc;
        e.bd     = mBd;
        e.buserr = mBusErr;
        if (rst) begin
            if (mInExc) begin
                e.flush  = 4'hF;
                e.redir  = 1'b1;
                e.target = VEC;
            end else if (ex)            e.flush = 4'hF;
            else if (dw)                e.stall = 5'b11110;
            else if (lu)                e.stall = 5'b11000;
            else if (!IF_MemReady)      e.stall = 5'b10000;
        end
        expQ.push_back(e);
        tagQ.push_back(tag);

        @(negedge clk);
        got = {IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall,
               IF_Flush, ID_Flush, EX_Flush, MEM_Flush,
               PC_Redirect, PC_Target, EPC, ExcBD, ExcBusErr};
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput({t, ".stall"},  32'(got.stall),  32'(e.stall));
        checkOutput({t, ".flush"},  32'(got.flush),  32'(e.flush));
        checkOutput({t, ".redir"},  32'(got.redir),  32'(e.redir));
        checkOutput({t, ".target"}, got.target,      e.target);
        checkOutput({t, ".epc"},    got.epc,         e.epc);
        checkOutput({t, ".bd"},     32'(got.bd),     32'(e.bd));
        checkOutput({t, ".buserr"}, 32'(got.buserr), 32'(e.buserr));

        @(posedge clk);
        if (rst) begin
            if (mInExc) begin
                mInExc = 0;
                mCnt   = 0;
            end else if (ex) begin
                mEpc    = MEM_RestartPC;
                mBd     = MEM_IsBDS;
                mBusErr = to;
                mInExc  = 1;
                mCnt    = 0;
            end else begin
                mCnt = dw ? mCnt + 1 : 0;
            end
        end
        #1;
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;
        #2 rst = 1'b0;
        applyStimulus("reset0");
        applyStimulus("reset1");
        rst = 1'b1;
        applyStimulus("idle");

        // EX load feeding an EX consumer, then the same with $zero
        ID_Rs = 5'd5; ID_WantRs = 1'b1; EX_RtRd = 5'd5; EX_MemRead = 1'b1; EX_RegWrite = 1'b1;
        applyStimulus("ex_lu");
        EX_RtRd = '0; EX_MemRead = 1'b0; EX_RegWrite = 1'b0;
        MEM_RtRd = 5'd5; MEM_MemRead = 1'b1; MEM_RegWrite = 1'b1;
        applyStimulus("ex_lu_fwd");
        clearInputs();
        ID_Rs = 5'd0; ID_WantRs = 1'b1; EX_RtRd = 5'd0; EX_MemRead = 1'b1; EX_RegWrite = 1'b1;
        applyStimulus("ex_lu_r0");

        // MEM load feeding a branch compare
        clearInputs();
        ID_NeedRt = 1'b1; ID_Rt = 5'd7; MEM_RtRd = 5'd7; MEM_MemRead = 1'b1;
        applyStimulus("mem_lu");
        MEM_MemRead = 1'b0; MEM_RegWrite = 1'b1;
        applyStimulus("mem_fwd");
        clearInputs();
        ID_NeedRs = 1'b1; ID_Rs = 5'd9; EX_RtRd = 5'd9; EX_RegWrite = 1'b1;
        applyStimulus("ex_alu_branch");
        clearInputs();
        IF_MemReady = 1'b0;
        applyStimulus("imem_wait");

        // Data-memory wait, with a load-use hazard overlapping the first cycle
        clearInputs();
        MEM_MemRead = 1'b1; MEM_MemReady = 1'b0;
        ID_Rs = 5'd3; ID_WantRs = 1'b1; EX_RtRd = 5'd3; EX_MemRead = 1'b1;
        applyStimulus("dwait1");
        EX_MemRead = 1'b0;
        applyStimulus("dwait2");
        applyStimulus("dwait3");
        MEM_MemReady = 1'b1;
        applyStimulus("dwait_ready");

        // Exception in a delay slot
        clearInputs();
        MEM_Exception = 1'b1; MEM_RestartPC = 32'h0040_0010; MEM_IsBDS = 1'b1;
        applyStimulus("exc_T");
        clearInputs();
        MEM_Exception = 1'b1;
        applyStimulus("exc_T1");
        clearInputs();
        applyStimulus("exc_T2");

        // Exception colliding with a data-memory wait
        MEM_Exception = 1'b1; MEM_RestartPC = 32'h0040_0100; MEM_MemRead = 1'b1; MEM_MemReady = 1'b0;
        applyStimulus("exc_dw");
        clearInputs();
        applyStimulus("exc_dw_exc");

        // Bus-error timeout on a hung store
        clearInputs();
        MEM_MemWrite = 1'b1; MEM_MemReady = 1'b0; MEM_RestartPC = 32'h0040_0200;
        for (int i = 1; i <= TIMEOUT; i++) applyStimulus($sformatf("tmo%0d", i));
        applyStimulus("tmo_exc");
        clearInputs();
        applyStimulus("tmo_run");

        // Reset in the middle of EXC
        MEM_Exception = 1'b1; MEM_RestartPC = 32'h0040_0300;
        applyStimulus("rst_exc_T");
        clearInputs();
        rst = 1'b0;
        applyStimulus("rst_in_exc");
        rst = 1'b1;
        applyStimulus("rst_exc_after");

        // Reset in the middle of a data-memory stall
        MEM_MemRead = 1'b1; MEM_MemReady = 1'b0;
        applyStimulus("rst_dw1");
        applyStimulus("rst_dw2");
        rst = 1'b0;
        applyStimulus("rst_in_dw");
        rst = 1'b1;
        applyStimulus("rst_dw_after");
        clearInputs();
        applyStimulus("rst_dw_idle");

        // Random traffic with a small register range to provoke matches
        for (int i = 0; i < 80; i++) begin
            IF_MemReady   = ($urandom_range(0, 3) != 0);
            ID_Rs         = 5'($urandom_range(0, 3));
            ID_Rt         = 5'($urandom_range(0, 3));
            ID_NeedRs     = 1'($urandom_range(0, 1));
            ID_NeedRt     = 1'($urandom_range(0, 1));
            ID_WantRs     = 1'($urandom_range(0, 1));
            ID_WantRt     = 1'($urandom_range(0, 1));
            EX_RtRd       = 5'($urandom_range(0, 3));
            EX_RegWrite   = 1'($urandom_range(0, 1));
            EX_MemRead    = 1'($urandom_range(0, 1));
            MEM_RtRd      = 5'($urandom_range(0, 3));
            MEM_RegWrite  = 1'($urandom_range(0, 1));
            MEM_MemRead   = 1'($urandom_range(0, 1));
            MEM_MemWrite  = 1'($urandom_range(0, 1));
            MEM_MemReady  = ($urandom_range(0, 2) != 0);
            MEM_Exception = ($urandom_range(0, 15) == 0);
            MEM_RestartPC = $urandom;
            MEM_IsBDS     = 1'($urandom_range(0, 1));
            applyStimulus($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

endmodule
